// File: rtl/bucket_select_pkg.sv
// ---------------------------------------------------------------------------
// bucket_select_pkg
//   Shared definitions for the bucket select engine:
//     - state_e   : engine FSM encoding (ST_IDLE / ST_SCAN / ST_DONE)
//     - idx_width : tag width for K entries per vector
//     - val_width : key / bucket index width for SIZE buckets
//     - entry_width : packed entry width {tag, key}
// ---------------------------------------------------------------------------
package bucket_select_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int idx_width(input int k);
        return $clog2(k);
    endfunction

    function automatic int val_width(input int size);
        return $clog2(size);
    endfunction

    function automatic int entry_width(input int k, input int size);
        return $clog2(k) + $clog2(size);
    endfunction

endpackage

// File: rtl/bucket_match_lane.sv
// ---------------------------------------------------------------------------
// bucket_match_lane
//   Combinational matcher for one bucket. Compares every registered entry key
//   against the bucket index and returns the tag of the lowest-numbered match.
//
//   Ports:
//     bucket  in   VAL_W        bucket index being evaluated
//     entries in   K*ENTRY_W    entry j at [j*ENTRY_W +: ENTRY_W], key in low bits
//     tag     out  IDX_W        tag of lowest matching entry (0 when no match)
//     hit     out  1            at least one entry matched
//     dup     out  1            two or more entries matched
//                               (only when BUCKET_SELECT_DUP_DETECT_EN is defined)
// ---------------------------------------------------------------------------
module bucket_match_lane
    import bucket_select_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int K    = 8,
    localparam int IDX_W   = idx_width(K),
    localparam int VAL_W   = val_width(SIZE),
    localparam int ENTRY_W = entry_width(K, SIZE)
) (
    input  logic [VAL_W-1:0]     bucket,
    input  logic [K*ENTRY_W-1:0] entries,
    output logic [IDX_W-1:0]     tag,
    output logic                 hit
`ifdef BUCKET_SELECT_DUP_DETECT_EN
    ,
    output logic                 dup
`endif
);

    // Ascending scan: the first match claims the tag, so later matches can
    // only flag a duplicate and never override the lowest-index winner.
    always_comb begin
        tag = '0;
        hit = 1'b0;
`ifdef BUCKET_SELECT_DUP_DETECT_EN
        dup = 1'b0;
`endif
        for (int j = 0; j < K; j++) begin
            if (entries[j*ENTRY_W +: VAL_W] == bucket) begin
                if (!hit) begin
                    hit = 1'b1;
                    tag = entries[j*ENTRY_W + VAL_W +: IDX_W];
                end
`ifdef BUCKET_SELECT_DUP_DETECT_EN
                else begin
                    dup = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/bucket_select_engine.sv
// ---------------------------------------------------------------------------
// bucket_select_engine
//   Handshaked bucket selector. Accepts a vector of K tagged entries, then
//   scans all SIZE buckets LANES at a time over PASSES = SIZE/LANES cycles.
//   For each bucket it reports the tag of the lowest-numbered entry whose key
//   equals the bucket index, plus a hit flag.
//
//   Optional feature macro: BUCKET_SELECT_DUP_DETECT_EN adds the dup output.
//
//   Ports:
//     clk         in   1           system clock
//     rst_n       in   1           asynchronous active-low reset
//     in_valid    in   1           input vector valid
//     in_ready    out  1           engine idle and able to accept
//     in_entries  in   K*ENTRY_W   entry j at [j*ENTRY_W +: ENTRY_W]
//     out_valid   out  1           results complete and stable
//     out_ready   in   1           consumer accepts results
//     results     out  SIZE*IDX_W  tag for bucket n at [n*IDX_W +: IDX_W]
//     hits        out  SIZE        hits[n] set when some entry has key n
//     dup         out  SIZE        dup[n] set when two or more entries have key n
// ---------------------------------------------------------------------------
module bucket_select_engine
    import bucket_select_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int K     = 8,
    parameter int LANES = 4,
    localparam int IDX_W   = idx_width(K),
    localparam int VAL_W   = val_width(SIZE),
    localparam int ENTRY_W = entry_width(K, SIZE),
    localparam int PASSES  = SIZE / LANES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K*ENTRY_W-1:0]  in_entries,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE*IDX_W-1:0] results,
    output logic [SIZE-1:0]       hits
`ifdef BUCKET_SELECT_DUP_DETECT_EN
    ,
    output logic [SIZE-1:0]       dup
`endif
);

    // A single-pass build still needs a one-bit counter to keep widths legal.
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    state_e                state_q,   state_d;
    logic [PASS_W-1:0]     pass_q,    pass_d;
    logic [K*ENTRY_W-1:0]  entries_q, entries_d;
    logic [SIZE*IDX_W-1:0] results_q, results_d;
    logic [SIZE-1:0]       hits_q,    hits_d;
`ifdef BUCKET_SELECT_DUP_DETECT_EN
    logic [SIZE-1:0]       dup_q,     dup_d;
    logic [LANES-1:0]      lane_dup;
`endif

    logic [VAL_W-1:0] lane_bucket [LANES];
    logic [IDX_W-1:0] lane_tag    [LANES];
    logic [LANES-1:0] lane_hit;

    // Lane l always looks at bucket pass*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_bucket[l] = VAL_W'(32'(pass_q) * 32'(LANES) + 32'(l));

        bucket_match_lane #(
            .SIZE (SIZE),
            .K    (K)
        ) u_lane (
            .bucket  (lane_bucket[l]),
            .entries (entries_q),
            .tag     (lane_tag[l]),
            .hit     (lane_hit[l])
`ifdef BUCKET_SELECT_DUP_DETECT_EN
            ,
            .dup     (lane_dup[l])
`endif
        );
    end

    // Next-state and datapath update. Result slots are addressed with
    // constant indices: bucket n belongs to pass n/LANES and lane n%LANES.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        entries_d = entries_q;
        results_d = results_q;
        hits_d    = hits_q;
`ifdef BUCKET_SELECT_DUP_DETECT_EN
        dup_d     = dup_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    entries_d = in_entries;
                    results_d = '0;
                    hits_d    = '0;
`ifdef BUCKET_SELECT_DUP_DETECT_EN
                    dup_d     = '0;
`endif
                    pass_d    = '0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                for (int n = 0; n < SIZE; n++) begin
                    if (pass_q == PASS_W'(n / LANES)) begin
                        results_d[n*IDX_W +: IDX_W] = lane_tag[n % LANES];
                        hits_d[n]                   = lane_hit[n % LANES];
`ifdef BUCKET_SELECT_DUP_DETECT_EN
                        dup_d[n]                    = lane_dup[n % LANES];
`endif
                    end
                end
                if (pass_q == LAST_PASS) begin
                    pass_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    pass_d  = pass_q + PASS_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pass_q    <= '0;
            entries_q <= '0;
            results_q <= '0;
            hits_q    <= '0;
`ifdef BUCKET_SELECT_DUP_DETECT_EN
            dup_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            entries_q <= entries_d;
            results_q <= results_d;
            hits_q    <= hits_d;
`ifdef BUCKET_SELECT_DUP_DETECT_EN
            dup_q     <= dup_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign results   = results_q;
    assign hits      = hits_q;
`ifdef BUCKET_SELECT_DUP_DETECT_EN
    assign dup       = dup_q;
`endif

endmodule
